// File: rtl/led_pattern_gen_pkg.sv
// Shared mode encoding and scan-direction constants for the LED pattern generator.
// Pure definitions: no latency, no backpressure.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_UP    = 2'd0,
    MODE_DOWN  = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  localparam logic SCAN_LEFT  = 1'b0;
  localparam logic SCAN_RIGHT = 1'b1;

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Clock divider: counts 0..CLK_DIV-1 while en, strobing tick combinationally in the wrap cycle.
// Latency: strobe is high in the cycle whose closing edge wraps; clr wins over a coincident wrap; en=0 holds.
module tick_prescaler #(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // The caller registers this strobe so its own step and tick land on the same edge.
  assign tick = en && !clr && wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// N-LED pattern generator (UP/DOWN/SCAN/BLINK) stepped by an internal divider; LED_DIM_EN adds PWM dimming via duty.
// Latency: leds and tick update on the same edge, every CLK_DIV enabled cycles; mode_ld restarts on the next edge.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LEDS  = 8,
  parameter int CLK_DIV = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode_in,
  input  logic              mode_ld,
`ifdef LED_DIM_EN
  input  logic [3:0]        duty,
`endif
  output logic [N_LEDS-1:0] leds,
  output logic              tick,
  output logic [1:0]        mode_o
);

  localparam logic [N_LEDS-1:0] ONE      = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] ALL_ONES = '1;

  logic              step;
  mode_t             mode_q, mode_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              dir_q, dir_d;
  logic              tick_q, tick_d;

  tick_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (mode_ld),
    .tick (step)
  );

  always_comb begin
    mode_d = mode_q;
    leds_d = leds_q;
    dir_d  = dir_q;
    tick_d = step;
    if (mode_ld) begin
      mode_d = mode_t'(mode_in);
      dir_d  = SCAN_LEFT;
      case (mode_t'(mode_in))
        MODE_DOWN: leds_d = ALL_ONES;
        MODE_SCAN: leds_d = ONE;
        default:   leds_d = '0;
      endcase
    end else if (step) begin
      case (mode_q)
        MODE_UP:   leds_d = leds_q + ONE;
        MODE_DOWN: leds_d = leds_q - ONE;
        MODE_SCAN: begin
          // Direction flips on the step that lights an end LED, so ends never dwell twice.
          if (N_LEDS == 1) begin
            leds_d = ONE;
          end else if (dir_q == SCAN_LEFT) begin
            leds_d = leds_q << 1;
            if (leds_d[N_LEDS-1]) dir_d = SCAN_RIGHT;
          end else begin
            leds_d = leds_q >> 1;
            if (leds_d[0]) dir_d = SCAN_LEFT;
          end
        end
        default:   leds_d = (leds_q == '0) ? ALL_ONES : '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_UP;
      leds_q <= '0;
      dir_q  <= SCAN_LEFT;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      leds_q <= leds_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
    end
  end

  assign tick   = tick_q;
  assign mode_o = mode_q;

`ifdef LED_DIM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= 4'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign leds = leds_q & {N_LEDS{pwm_cnt_q < duty}};
`else
  assign leds = leds_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (N_LEDS=4, CLK_DIV=4) plus an N_LEDS=1 instance.
module tb_led_pattern_gen;

  typedef struct {
    logic [3:0] leds;
    int         gap;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode_in;
  logic       mode_ld;
  logic [3:0] leds;
  logic       tick;
  logic [1:0] mode_o;
  logic [1:0] mode_in1;
  logic       mode_ld1;
  logic [0:0] leds1;
  logic       tick1;
  logic [1:0] mode_o1;
`ifdef LED_DIM_EN
  logic [3:0] duty;
`endif

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   last_tick;
  int   tick_cnt;
  logic ld_at_edge;
  logic [3:0] prev_leds;

  led_pattern_gen #(.N_LEDS(4), .CLK_DIV(4)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode_in(mode_in),
    .mode_ld(mode_ld),
`ifdef LED_DIM_EN
    .duty   (duty),
`endif
    .leds   (leds),
    .tick   (tick),
    .mode_o (mode_o)
  );

  led_pattern_gen #(.N_LEDS(1), .CLK_DIV(2)) u_one (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode_in(mode_in1),
    .mode_ld(mode_ld1),
`ifdef LED_DIM_EN
    .duty   (duty),
`endif
    .leds   (leds1),
    .tick   (tick1),
    .mode_o (mode_o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    ld_at_edge <= mode_ld;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] v, input int gap);
    exp_t e;
    e.leds = v;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    #1;
    chk(nm, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every tick pops one expected step and checks value and spacing.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
`ifdef LED_DIM_EN
      if (tick) tick_cnt++;
`else
      if (tick) begin
        exp_t e;
        tick_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick actual_leds=%h expected=no_tick", leds);
        end else begin
          e = sb.pop_front();
          chk("step_leds", 32'(leds), 32'(e.leds));
          if (e.gap != 0) chk("step_gap", 32'(cyc - last_tick), 32'(e.gap));
        end
        chk("tick_with_change", 32'(leds !== prev_leds), 32'd1);
        last_tick = cyc;
      end else if (leds !== prev_leds && !ld_at_edge) begin
        checks++;
        errors++;
        $display("FAIL change_without_tick actual=%h previous=%h", leds, prev_leds);
      end
`endif
      prev_leds = leds;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [3:0] scan_seq [16];
    int cnt;
    int duties [3];
    scan_seq = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4,
                 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4};
    duties = '{4, 0, 15};
    checks = 0; errors = 0; cyc = 0; last_tick = 0; tick_cnt = 0;
    prev_leds = 4'h0; ld_at_edge = 1'b0;
    rst_n = 1'b0; en = 1'b0; mode_in = 2'd0; mode_ld = 1'b0;
    mode_in1 = 2'd0; mode_ld1 = 1'b0;
`ifdef LED_DIM_EN
    duty = 4'd0;
`endif
    nclk(3);
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_mode", 32'(mode_o), 32'h0);
    rst_n = 1'b1;
    en    = 1'b1;

`ifdef LED_DIM_EN
    mode_in = 2'd3; mode_ld = 1'b1;
    nclk(1);
    mode_ld = 1'b0;
    nclk(4);
    en = 1'b0;
    chk("dim_tick_count", 32'(tick_cnt), 32'd1);
    for (int d = 0; d < 3; d++) begin
      duty = 4'(duties[d]);
      cnt  = 0;
      for (int i = 0; i < 16; i++) begin
        nclk(1);
        if (leds === 4'hF) cnt++;
        else if (leds !== 4'h0) chk("dim_all_or_none", 32'(leds), 32'hF);
      end
      chk("dim_on_cycles", 32'(cnt), 32'(duties[d]));
    end
    chk("dim_mode", 32'(mode_o), 32'h3);
`else
    // UP: 1..15,0 then on to 5.
    for (int i = 1; i <= 21; i++) push(4'(i % 16), (i == 1) ? 0 : 4);
    nclk(3);
    chk("before_first_step", 32'(leds), 32'h0);
    nclk(1);
    chk("first_step_cycle4", 32'(leds), 32'h1);
    chk("first_tick", 32'(tick), 32'h1);
    nclk(80);
    chk("up_at_5", 32'(leds), 32'h5);
    drain("drain_up");

    // DOWN from 5: reload to all-ones, count down, wrap 0 -> F.
    for (int v = 14; v >= 0; v--) push(4'(v), (v == 14) ? 5 : 4);
    push(4'hF, 4);
    mode_in = 2'd1; mode_ld = 1'b1;
    nclk(1);
    mode_ld = 1'b0;
    chk("down_load_leds", 32'(leds), 32'hF);
    chk("down_load_mode", 32'(mode_o), 32'h1);
    chk("down_load_tick", 32'(tick), 32'h0);
    nclk(64);
    drain("drain_down");

    // SCAN bounce, and the single-LED instance held at 1.
    for (int i = 0; i < 16; i++) push(scan_seq[i], (i == 0) ? 5 : 4);
    mode_in = 2'd2; mode_ld = 1'b1;
    mode_in1 = 2'd2; mode_ld1 = 1'b1;
    nclk(1);
    mode_ld = 1'b0; mode_ld1 = 1'b0;
    chk("scan_load_leds", 32'(leds), 32'h1);
    chk("scan_load_mode", 32'(mode_o), 32'h2);
    for (int i = 0; i < 4; i++) begin
      nclk(16);
      chk("one_led_scan", 32'(leds1), 32'h1);
    end
    drain("drain_scan");

    // BLINK with a 10-cycle freeze at divider=2.
    push(4'hF, 5); push(4'h0, 14); push(4'hF, 4); push(4'h0, 4);
    mode_in = 2'd3; mode_ld = 1'b1;
    nclk(1);
    mode_ld = 1'b0;
    chk("blink_load_leds", 32'(leds), 32'h0);
    chk("blink_load_mode", 32'(mode_o), 32'h3);
    nclk(6);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nclk(1);
      chk("freeze_leds", 32'(leds), 32'hF);
      chk("freeze_tick", 32'(tick), 32'h0);
    end
    en = 1'b1;
    nclk(1);
    chk("resume_one_cycle", 32'(leds), 32'hF);
    nclk(9);
    drain("drain_blink");

    // UP to 7, then mode_ld lands exactly on the step edge.
    for (int i = 1; i <= 7; i++) push(4'(i), (i == 1) ? 5 : 4);
    push(4'h2, 8);
    mode_in = 2'd0; mode_ld = 1'b1;
    nclk(1);
    mode_ld = 1'b0;
    chk("up_reload_leds", 32'(leds), 32'h0);
    nclk(31);
    chk("pre_collision_leds", 32'(leds), 32'h7);
    mode_in = 2'd2; mode_ld = 1'b1;
    nclk(1);
    mode_ld = 1'b0;
    chk("ld_beats_step_leds", 32'(leds), 32'h1);
    chk("ld_beats_step_tick", 32'(tick), 32'h0);
    chk("ld_beats_step_mode", 32'(mode_o), 32'h2);
    nclk(4);
    chk("restart_first_step", 32'(leds), 32'h2);
    nclk(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_leds", 32'(leds), 32'h0);
    chk("async_rst_mode", 32'(mode_o), 32'h0);
    chk("async_rst_tick", 32'(tick), 32'h0);
    chk("drain_final", 32'(sb.size()), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the fixed 8-bit LED counter: N-LED pattern generator driven by an internal clock-divider tick.
- Four runtime-selectable modes: count up, count down, bouncing scan, blink. Also supports pause/enable.
- Top-level board peripheral between the board clock/reset and the LED pins; also drives a tick strobe other logic can use.

Parameters:
- N_LEDS, 8, number of LEDs / pattern width (>=1).
- CLK_DIV, 20, clk cycles per pattern step (>=2); board build uses 1200000 for 10 Hz at 12 MHz.
- DIV_W, $clog2(CLK_DIV), width of the divider counter; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  1 = run; 0 = freeze divider and pattern.
- mode_in  in  2  requested mode: 0 UP, 1 DOWN, 2 SCAN, 3 BLINK.
- mode_ld  in  1  single-cycle strobe; loads mode_in.
- leds  out  N_LEDS  LED drive, active-high.
- tick  out  1  one-cycle pulse on each pattern step.
- mode_o  out  2  current mode.

Behaviour:
- Reset (async assert, sync-released use): leds=0, tick=0, mode_o=UP, divider=0, scan_dir=left.
- Divider: counts 0..CLK_DIV-1 while en=1.
  - At CLK_DIV-1 it wraps to 0 and the step fires.
  - tick is registered and is high in the cycle after the wrap edge, i.e. coincident with the leds update.
  - From reset with en=1, the first leds change occurs at cycle CLK_DIV.
- en=0: divider, leds and scan_dir hold; tick=0. Resuming continues from the held divider value, with no restart.
- mode_ld=1 (regardless of en):
  - Next edge sets mode_o=mode_in, clears the divider and sets tick=0.
  - Loads the start pattern: UP 0, DOWN all-ones, SCAN bit0 set with scan_dir=left, BLINK 0.
  - mode_ld wins over a coincident step; that step is dropped.
  - Reloading the same mode also restarts it.
- UP: leds+1 modulo 2^N_LEDS; all-ones wraps to 0.
- DOWN: leds-1 modulo 2^N_LEDS; 0 wraps to all-ones.
- SCAN: one-hot pattern.
  - Left shifts toward the MSB. On reaching the MSB, scan_dir flips to right on the same step that sets the MSB; the LSB behaves symmetrically.
  - The end LEDs are lit for one step each, with no double dwell.
  - Sequence for N=4: 0001,0010,0100,1000,0100,0010,0001,0010...
  - N_LEDS=1: constant 1.
- BLINK: leds toggles between all-zero and all-ones each step.
- Illegal states cannot occur; all 2-bit mode codes are defined.
- Reset mid-operation aborts immediately to reset values.

Optional Feature:
- Macro LED_DIM_EN.
- Defined:
  - Adds input port duty (4 bits) and a free-running 4-bit PWM counter pwm_cnt, reset 0, incrementing every clk regardless of en.
  - LED output is leds_pat & {N_LEDS{pwm_cnt < duty}}: duty=0 gives always off; duty=15 gives on 15/16 of cycles.
  - Pattern state is unaffected by duty.
- Undefined: duty port absent; leds = pattern register directly, with no extra logic.

Decomposition:
- Package led_pkg: mode_t enum (MODE_UP=2'd0, MODE_DOWN=2'd1, MODE_SCAN=2'd2, MODE_BLINK=2'd3); SCAN_LEFT/SCAN_RIGHT direction constants.
- Sub-module tick_prescaler (params CLK_DIV; ports clk, rst_n, en, clr, tick) holds the divider. Top holds mode/pattern registers and the optional PWM.

Test Plan (N_LEDS=4, CLK_DIV=4 unless stated):
1. Reset then en=1, mode UP, run 80 cycles -> leds steps 0,1,2..15,0 every 4 cycles; tick high exactly in the cycles leds changes; first change at cycle 4.
2. mode_ld with DOWN at leds=5 -> next edge leds=1111, mode_o=1; after 4 cycles 1110; 0000 later wraps to 1111.
3. SCAN for 16 steps -> exact bounce sequence 0001,0010,0100,1000,0100,0010,0001,0010,...; also N_LEDS=1 build stays 1.
4. BLINK, drop en for 10 cycles mid-period at divider=2 -> leds and tick frozen; after en=1 the next toggle comes 2 cycles later (continued count, not restart).
5. mode_ld asserted on the exact step cycle in UP at leds=7, mode_in=SCAN -> leds=0001, no 1000 step, divider restarts; then assert rst_n=0 asynchronously mid-period -> leds=0, mode_o=0 without waiting for clk.
6. LED_DIM_EN build, BLINK all-ones phase, duty=4 -> each LED high 4 of every 16 clk; duty=0 -> always 0; duty=15 -> 15 of 16.
